// File: rtl/sram_pkg.sv
// Shared definitions for the 32-bit-to-16-bit SRAM controller.
// Contents: controller state enum, default timing/base parameters, SRAM bus
// widths and the byte-address to SRAM-word translation helper.
package sram_pkg;

  localparam int unsigned DefaultPhaseCycles = 2;
  localparam int unsigned DefaultBaseAddr    = 1024;

  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned SRAM_DQ_W   = 16;

  // One 32-bit word occupies two consecutive half-word locations.
  localparam int unsigned WordW = SRAM_ADDR_W - 1;

  typedef enum logic [1:0] {
    StIdle,
    StLow,
    StHigh,
    StDone
  } state_e;

  // Addresses below base wrap silently; the truncation to WordW bits is the modulo.
  function automatic logic [WordW-1:0] word_index(input logic [31:0] address,
                                                   input logic [31:0] base);
    return WordW'((address - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_controller.sv
// sram_controller: splits each 32-bit load/store from the memory stage into a
// low-half and a high-half access on a 16-bit asynchronous SRAM.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   wr_en, rd_en        store / load request (held until ready=1)
//   address             byte address, bits [1:0] ignored
//   write_data          store data
//   read_data           registered load result, held between loads
//   ready               0 stalls the pipeline while an access is in flight
//   SRAM_DQ             bidirectional SRAM data bus, driven only in write phases
//   SRAM_ADDR           SRAM half-word address
//   SRAM_UB_N/LB_N/CE_N tied active
//   SRAM_WE_N/OE_N      active-low write / output enables
module sram_controller
  import sram_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES = DefaultPhaseCycles,
  parameter int unsigned BASE_ADDR    = DefaultBaseAddr
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  inout  wire  [SRAM_DQ_W-1:0]   SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N
);

  localparam int unsigned PhaseW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(PHASE_CYCLES - 1);

  state_e                 state_q;
  logic [PhaseW-1:0]      phase_q;
  logic                   op_write_q;
  logic [WordW-1:0]       word_q;
  logic [SRAM_DQ_W-1:0]   wdata_hi_q;
  logic [SRAM_DQ_W-1:0]   dq_out_q;
  logic                   dq_oe_q;
  logic [31:0]            read_data_q;
  logic [SRAM_ADDR_W-1:0] sram_addr_q;
  logic                   we_n_q;
  logic                   oe_n_q;

  logic                   request;
  logic                   phase_last;
  logic [WordW-1:0]       req_word;

  assign request    = wr_en | rd_en;
  assign phase_last = (phase_q == PhaseLast);
  assign req_word   = word_index(address, 32'(BASE_ADDR));

  // Controller FSM; all SRAM strobes are registered alongside the state so they
  // change on the same edge as the phase they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      phase_q     <= '0;
      op_write_q  <= 1'b0;
      word_q      <= '0;
      wdata_hi_q  <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (request) begin
            // A simultaneous load and store resolves to the store.
            state_q     <= StLow;
            phase_q     <= '0;
            op_write_q  <= wr_en;
            word_q      <= req_word;
            wdata_hi_q  <= write_data[31:16];
            sram_addr_q <= {req_word, 1'b0};
            dq_out_q    <= write_data[15:0];
            dq_oe_q     <= wr_en;
            we_n_q      <= ~wr_en;
            oe_n_q      <= wr_en;
          end
        end
        StLow: begin
          if (phase_last) begin
            if (!op_write_q) begin
              read_data_q[15:0] <= SRAM_DQ;
            end
            state_q     <= StHigh;
            phase_q     <= '0;
            sram_addr_q <= {word_q, 1'b1};
            dq_out_q    <= wdata_hi_q;
          end else begin
            phase_q <= phase_q + PhaseW'(1);
          end
        end
        StHigh: begin
          if (phase_last) begin
            if (!op_write_q) begin
              read_data_q[31:16] <= SRAM_DQ;
            end
            state_q <= StDone;
            phase_q <= '0;
            dq_oe_q <= 1'b0;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b0;
          end else begin
            phase_q <= phase_q + PhaseW'(1);
          end
        end
        StDone: begin
          // Requests still held here belong to the access just finished.
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    ready = (state_q == StDone) | ((state_q == StIdle) & ~request);
  end

  assign SRAM_DQ   = dq_oe_q ? dq_out_q : {SRAM_DQ_W{1'bz}};
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign read_data = read_data_q;

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Sequences 32-bit load/store requests from the memory stage onto the 16-bit off-chip SRAM: one low-half and one high-half bus access per word.
- Drives `ready` low while an access is in flight so the pipeline freezes, then returns `read_data` to the next stage.
- Sits between the memory stage and the SRAM pins.
- Owns all SRAM control strobes and the tri-state data bus.

Parameters:
- PHASE_CYCLES, 2: cycles each 16-bit half-access is held on the bus; must be >= 1.
- BASE_ADDR, 1024: byte address mapped to SRAM word 0; subtracted before translation.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  store request from the memory stage.
- rd_en  input  1  load request from the memory stage.
- address  input  32  byte address; bits [1:0] ignored.
- write_data  input  32  store data.
- read_data  output  32  registered load result.
- ready  output  1  0 = freeze the pipeline; 1 = memory stage may advance.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  output  18  SRAM half-word address.
- SRAM_UB_N  output  1  high-byte mask, constant 0.
- SRAM_LB_N  output  1  low-byte mask, constant 0.
- SRAM_WE_N  output  1  write enable, active low.
- SRAM_CE_N  output  1  chip enable, constant 0.
- SRAM_OE_N  output  1  output enable, active low.

Behaviour:
- Clock and reset: one clock, `clk`; reset `rst` is asynchronous and active-high.
- States: IDLE, LOW, HIGH, DONE.
- Reset (asynchronous, immediate, including mid-access):
  - state=IDLE, phase counter=0, read_data=0, latched op/address/data cleared.
  - SRAM_WE_N=1, SRAM_OE_N=0, SRAM_ADDR=0, SRAM_DQ=Z.
- IDLE:
  - Request = wr_en|rd_en.
  - If a request is present: latch op (write if wr_en, else read), word address and write_data; go to LOW.
  - If wr_en and rd_en are both high, the write wins and read_data is unchanged.
- Address translation:
  - word = ((address - BASE_ADDR) >> 2), modulo 2^17.
  - LOW drives SRAM_ADDR = {word[16:0],0}; HIGH drives {word[16:0],1}.
  - Wrap-around for addresses below BASE_ADDR is by modulo; no error is flagged.
- LOW and HIGH each last exactly PHASE_CYCLES cycles, counted by the phase counter; it resets to 0 on each phase entry.
- LOW -> HIGH -> DONE.
- Write phases:
  - SRAM_WE_N=0 and SRAM_OE_N=1.
  - SRAM_DQ drives write_data[15:0] in LOW and write_data[31:16] in HIGH.
- Read phases:
  - SRAM_WE_N=1, SRAM_OE_N=0, SRAM_DQ=Z.
  - read_data[15:0] captures SRAM_DQ on the last cycle of LOW; read_data[31:16] captures it on the last cycle of HIGH.
- DONE:
  - Lasts one cycle; WE_N=1, DQ=Z.
  - Next state is always IDLE, regardless of the request inputs.
- ready is combinational: ready = (state==DONE) | (state==IDLE & ~(wr_en|rd_en)).
- Latency at PHASE_CYCLES=2:
  - Request seen at cycle 0; LOW at cycles 1-2; HIGH at cycles 3-4; DONE at cycle 5.
  - ready is 0 in cycles 0-4 and 1 in cycle 5.
  - General stall = 2*PHASE_CYCLES+1 cycles.
- Holding requests:
  - The memory stage holds its request until ready=1.
  - A request still asserted during DONE is not re-executed; the controller only samples requests again in IDLE.
- read_data holds its value between reads; writes never modify it.
- Outside write phases SRAM_DQ is always Z, so there is never bus contention.

Decomposition:
- Shared package sram_pkg:
  - state enum (IDLE, LOW, HIGH, DONE);
  - default PHASE_CYCLES and BASE_ADDR;
  - SRAM_ADDR_W=18 and SRAM_DQ_W=16 constants.
- Single module; no sub-module. The tri-state driver is one continuous assignment.

Test Plan:
- Reset: assert rst mid-stream -> immediately read_data=0, SRAM_WE_N=1, SRAM_DQ=Z, SRAM_ADDR=0; with no request, ready=1.
- Write: wr_en, address=1024, write_data=0xDEADBEEF ->
  - cycles 1-2: SRAM_ADDR=0, DQ=0xBEEF, WE_N=0;
  - cycles 3-4: SRAM_ADDR=1, DQ=0xDEAD;
  - ready=0 in cycles 0-4 and 1 in cycle 5.
- Read back: rd_en, address=1024, with an SRAM model holding that data -> read_data=0xDEADBEEF in cycle 5; DQ=Z throughout; OE_N=0.
- Address map: rd_en, address=1028 (and 1031) -> SRAM_ADDR 2 then 3; the 1031 case checks that bits [1:0] are ignored.
- Conflict and hold:
  - wr_en=rd_en=1 for 0x12345678 -> write performed and read_data unchanged.
  - Request held through DONE -> exactly one access; the next access starts only from IDLE.
- Reset mid-write: rst asserted in cycle 3 -> WE_N=1 and DQ=Z the same cycle, state IDLE; after release a new read completes in 6 cycles.
